// File: rtl/reg_bank_rw_if.sv
// Sir register bus: select/read/address/write-data from master, registered ack and read data back.
interface reg_bank_rw_if #(
  parameter int unsigned ADDRWIDTH = 8,
  parameter int unsigned DATAWIDTH = 32
);
  logic                 SirSel;
  logic                 SirRead;
  logic [ADDRWIDTH-1:0] SirAddr;
  logic [DATAWIDTH-1:0] SirWdat;
  logic                 SirDack;
  logic [DATAWIDTH-1:0] SirRdat;

  modport master (
    output SirSel, SirRead, SirAddr, SirWdat,
    input  SirDack, SirRdat
  );

  modport slave (
    input  SirSel, SirRead, SirAddr, SirWdat,
    output SirDack, SirRdat
  );
endinterface

// File: rtl/reg_bank_rw.sv
// Parameterised register bank on the Sir bus with per-register RW / RO / W1C / PULSE behaviour.
// One write per SirSel assertion; ack and read data are registered.
module reg_bank_rw #(
  parameter int unsigned                    ADDRWIDTH  = 8,
  parameter int unsigned                    DATAWIDTH  = 32,
  parameter int unsigned                    NUM_REGS   = 8,
  parameter logic [ADDRWIDTH-1:0]           BASEADDR   = 8'h10,
  parameter logic [NUM_REGS*DATAWIDTH-1:0]  INIT_VALUE = {NUM_REGS*DATAWIDTH{1'b0}},
  parameter logic [2*NUM_REGS-1:0]          REG_MODE   = {NUM_REGS{2'b00}}
) (
  input  logic                           clk,
  input  logic                           rst,
  reg_bank_rw_if.slave                   sir,
  output logic [NUM_REGS*DATAWIDTH-1:0]  Q,
  input  logic [NUM_REGS*DATAWIDTH-1:0]  HwIn,
  output logic [NUM_REGS-1:0]            WrStb
);

  typedef enum logic [1:0] {
    ModeRw    = 2'b00,
    ModeRo    = 2'b01,
    ModeW1c   = 2'b10,
    ModePulse = 2'b11
  } regMode_e;

  localparam int unsigned IdxW = ADDRWIDTH + 1;

  logic [IdxW-1:0]      idx;
  logic                 hit;
  logic                 wrEn;
  logic                 dackQ, dackDlyQ;
  logic [DATAWIDTH-1:0] rdatQ, rdatD, rdMux;
  logic [NUM_REGS-1:0]  wrSel, wrStbQ;
  logic [DATAWIDTH-1:0] regQ [NUM_REGS];
  logic [DATAWIDTH-1:0] regD [NUM_REGS];

  // One extra bit: addresses below BASEADDR wrap to a huge index and fail the range check.
  assign idx  = {1'b0, sir.SirAddr} - {1'b0, BASEADDR};
  assign hit  = sir.SirSel && (idx < IdxW'(NUM_REGS));
  // Only the first acked cycle of a transaction may write.
  assign wrEn = dackQ && !dackDlyQ && hit && !sir.SirRead;

  always_comb begin
    wrSel = '0;
    rdMux = '0;
    regD  = regQ;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx == IdxW'(i)) begin
        rdMux    = regQ[i];
        wrSel[i] = wrEn;
      end
      case (regMode_e'(REG_MODE[2*i +: 2]))
        ModeRw:    if (wrSel[i]) regD[i] = sir.SirWdat;
        ModeRo:    regD[i] = HwIn[i*DATAWIDTH +: DATAWIDTH];
        // Hardware set wins over a simultaneous software clear.
        ModeW1c:   regD[i] = (regQ[i] & ~(wrSel[i] ? sir.SirWdat : '0))
                             | HwIn[i*DATAWIDTH +: DATAWIDTH];
        ModePulse: regD[i] = wrSel[i] ? sir.SirWdat : '0;
      endcase
    end
    rdatD = (hit && sir.SirRead) ? rdMux : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dackQ    <= 1'b0;
      dackDlyQ <= 1'b0;
      rdatQ    <= '0;
      wrStbQ   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regQ[i] <= (regMode_e'(REG_MODE[2*i +: 2]) == ModePulse) ? '0
                   : INIT_VALUE[i*DATAWIDTH +: DATAWIDTH];
      end
    end else begin
      dackQ    <= hit;
      dackDlyQ <= dackQ;
      rdatQ    <= rdatD;
      wrStbQ   <= wrSel;
      regQ     <= regD;
    end
  end

  always_comb begin
    Q = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      Q[i*DATAWIDTH +: DATAWIDTH] = regQ[i];
    end
  end

  assign sir.SirDack = dackQ;
  assign sir.SirRdat = rdatQ;
  assign WrStb       = wrStbQ;

endmodule

// File: tb/tb_reg_bank_rw.sv
// Directed bench for reg_bank_rw: regs 0-2,6,7 RW, reg3 W1C, reg4 PULSE, reg5 RO.
module tb_reg_bank_rw;

  localparam logic [15:0]  Mode = 16'h0780;
  localparam logic [255:0] Init = {32'hCAFE0007, 32'h0, 32'h5A5A5A5A, 32'h0,
                                   32'h0, 32'h0, 32'h0, 32'h0};

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] Q;
  logic [255:0] HwIn;
  logic [7:0]   WrStb;
  int           errors = 0;
  int           checks = 0;

  reg_bank_rw_if #(.ADDRWIDTH(8), .DATAWIDTH(32)) sir ();

  reg_bank_rw #(
    .ADDRWIDTH (8),
    .DATAWIDTH (32),
    .NUM_REGS  (8),
    .BASEADDR  (8'h10),
    .INIT_VALUE(Init),
    .REG_MODE  (Mode)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sir  (sir),
    .Q    (Q),
    .HwIn (HwIn),
    .WrStb(WrStb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] regOf(input int i);
    return Q[i*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic busSet(input logic sel, input logic rd, input logic [7:0] a, input logic [31:0] d);
    sir.SirSel  = sel;
    sir.SirRead = rd;
    sir.SirAddr = a;
    sir.SirWdat = d;
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [31:0] d);
    busSet(1'b1, 1'b0, a, d);
    step();
    step();
    busSet(1'b0, 1'b0, 8'h00, 32'h0);
    step();
  endtask

  logic [255:0] snap;
  int           stbCycles;

  initial begin
    rst  = 1'b1;
    HwIn = '0;
    busSet(1'b0, 1'b0, 8'h00, 32'h0);
    step();
    checkVal("rst_dack", sir.SirDack, 1'b0);
    checkVal("rst_rdat", sir.SirRdat, 32'h0);
    checkVal("rst_stb", WrStb, 8'h00);
    checkVal("rst_q", Q, Init);
    step();
    rst = 1'b0;
    step();

    // RW write held four cycles
    busSet(1'b1, 1'b0, 8'h12, 32'hDEADBEEF);
    step();
    checkVal("rw_dack_c2", sir.SirDack, 1'b1);
    checkVal("rw_q_c2", regOf(2), 32'h0);
    step();
    checkVal("rw_q_c3", regOf(2), 32'hDEADBEEF);
    checkVal("rw_stb_c3", WrStb, 8'h04);
    step();
    checkVal("rw_stb_c4", WrStb, 8'h00);
    step();
    checkVal("rw_stb_c5", WrStb, 8'h00);
    busSet(1'b0, 1'b0, 8'h00, 32'h0);
    step();
    checkVal("rw_dack_off", sir.SirDack, 1'b0);
    busSet(1'b1, 1'b1, 8'h12, 32'h0);
    step();
    checkVal("rw_rd_dack", sir.SirDack, 1'b1);
    checkVal("rw_rd_dat", sir.SirRdat, 32'hDEADBEEF);
    busSet(1'b0, 1'b0, 8'h00, 32'h0);
    step();
    checkVal("rw_rd_idle", sir.SirRdat, 32'h0);

    // W1C on reg3
    HwIn[3*32 +: 32] = 32'h11;
    step();
    HwIn[3*32 +: 32] = 32'h0;
    step();
    checkVal("w1c_set", regOf(3), 32'h11);
    HwIn[3*32 +: 32] = 32'h1;
    doWrite(8'h13, 32'h01);
    HwIn[3*32 +: 32] = 32'h0;
    step();
    checkVal("w1c_setwins", regOf(3), 32'h11);
    doWrite(8'h13, 32'h10);
    checkVal("w1c_clr", regOf(3), 32'h01);
    busSet(1'b1, 1'b1, 8'h13, 32'h0);
    step();
    checkVal("w1c_rd", sir.SirRdat, 32'h01);
    step();
    checkVal("w1c_rd_noside", regOf(3), 32'h01);
    busSet(1'b0, 1'b0, 8'h00, 32'h0);
    step();

    // PULSE on reg4
    busSet(1'b1, 1'b0, 8'h14, 32'hA5);
    step();
    checkVal("pulse_pre", regOf(4), 32'h0);
    step();
    checkVal("pulse_on", regOf(4), 32'hA5);
    checkVal("pulse_stb", WrStb, 8'h10);
    step();
    checkVal("pulse_off", regOf(4), 32'h0);
    busSet(1'b1, 1'b1, 8'h14, 32'h0);
    step();
    checkVal("pulse_rd", sir.SirRdat, 32'h0);
    busSet(1'b0, 1'b0, 8'h00, 32'h0);
    step();

    // RO on reg5
    HwIn[5*32 +: 32] = 32'h33;
    step();
    checkVal("ro_sample", regOf(5), 32'h33);
    busSet(1'b1, 1'b0, 8'h15, 32'h55);
    step();
    checkVal("ro_dack", sir.SirDack, 1'b1);
    step();
    checkVal("ro_stb", WrStb, 8'h20);
    checkVal("ro_keep", regOf(5), 32'h33);
    busSet(1'b0, 1'b0, 8'h00, 32'h0);
    step();

    // Out-of-range below and above, then the last valid register
    snap = Q;
    busSet(1'b1, 1'b0, 8'h0F, 32'hFFFFFFFF);
    step();
    checkVal("lo_dack", sir.SirDack, 1'b0);
    step();
    checkVal("lo_stb", WrStb, 8'h00);
    busSet(1'b1, 1'b1, 8'h0F, 32'h0);
    step();
    checkVal("lo_rdat", sir.SirRdat, 32'h0);
    busSet(1'b1, 1'b0, 8'h18, 32'hFFFFFFFF);
    step();
    checkVal("hi_dack", sir.SirDack, 1'b0);
    step();
    checkVal("hi_stb", WrStb, 8'h00);
    busSet(1'b1, 1'b1, 8'h18, 32'h0);
    step();
    checkVal("hi_rdat", sir.SirRdat, 32'h0);
    checkVal("oor_q", Q, snap);
    busSet(1'b0, 1'b0, 8'h00, 32'h0);
    step();
    busSet(1'b1, 1'b1, 8'h17, 32'h0);
    step();
    checkVal("top_dack", sir.SirDack, 1'b1);
    checkVal("top_rdat", sir.SirRdat, 32'hCAFE0007);
    busSet(1'b0, 1'b0, 8'h00, 32'h0);
    step();

    // SirSel held 10 cycles while the address moves
    busSet(1'b1, 1'b0, 8'h10, 32'h111);
    step();
    step();
    checkVal("hold_first", regOf(0), 32'h111);
    stbCycles = 0;
    for (int k = 0; k < 8; k++) begin
      sir.SirAddr = 8'h11 + 8'(k % 3);
      sir.SirWdat = 32'hBAD0 + 32'(k);
      step();
      if (WrStb != 8'h00) stbCycles++;
    end
    busSet(1'b0, 1'b0, 8'h00, 32'h0);
    step();
    checkVal("hold_stb", stbCycles, 0);
    checkVal("hold_r1", regOf(1), 32'h0);
    checkVal("hold_r2", regOf(2), 32'hDEADBEEF);

    // Asynchronous reset inside a write, then release with SirSel still high
    busSet(1'b1, 1'b0, 8'h16, 32'h1234);
    step();
    checkVal("ar_dack_pre", sir.SirDack, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkVal("ar_dack", sir.SirDack, 1'b0);
    checkVal("ar_rdat", sir.SirRdat, 32'h0);
    checkVal("ar_stb", WrStb, 8'h00);
    checkVal("ar_r2", regOf(2), 32'h0);
    checkVal("ar_r5", regOf(5), 32'h5A5A5A5A);
    checkVal("ar_r6", regOf(6), 32'h0);
    step();
    step();
    rst = 1'b0;
    step();
    checkVal("ar_rel_dack", sir.SirDack, 1'b1);
    checkVal("ar_rel_r6pre", regOf(6), 32'h0);
    step();
    checkVal("ar_rel_r6", regOf(6), 32'h1234);
    checkVal("ar_rel_stb", WrStb, 8'h40);
    step();
    checkVal("ar_rel_stb2", WrStb, 8'h00);
    step();
    checkVal("ar_rel_stb3", WrStb, 8'h00);
    busSet(1'b0, 1'b0, 8'h00, 32'h0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_rw.md
REG_BANK_RW -- requirements
Module: reg_bank_rw

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
  ADDRWIDTH   8                    Sir address width
  DATAWIDTH   32                   register width
  NUM_REGS    8                    number of registers (1..2^ADDRWIDTH)
  BASEADDR    8'h10                address of register 0; register i at BASEADDR+i
  INIT_VALUE  {NUM_REGS*DATAWIDTH{1'b0}}   reset value; register i at bits [i*DATAWIDTH +: DATAWIDTH]
  REG_MODE    {NUM_REGS{2'b00}}    per-register mode, 2 bits each: 00 RW, 01 RO, 10 W1C, 11 PULSE
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning:
  clk      in   1                     single clock, all logic on rising edge
  rst      in   1                     asynchronous, active-high reset
  SirSel   in   1                     bus select, held high for a whole transaction
  SirRead  in   1                     1 read, 0 write
  SirAddr  in   ADDRWIDTH             bus address
  SirWdat  in   DATAWIDTH             write data
  SirDack  out  1                     registered acknowledge
  SirRdat  out  DATAWIDTH             registered read data
  Q        out  NUM_REGS*DATAWIDTH    flattened register contents
  HwIn     in   NUM_REGS*DATAWIDTH    hardware inputs for RO and W1C registers
  WrStb    out  NUM_REGS              one-cycle pulse per register on accepted write

Function
REQ-003 hit SHALL be SirSel=1 and BASEADDR <= SirAddr < BASEADDR+NUM_REGS; idx = SirAddr-BASEADDR, computed in ADDRWIDTH+1 bits so the range check never wraps.
REQ-004 SirDack SHALL be 1 in the cycle after every cycle with hit=1, otherwise 0.
REQ-005 A write SHALL be accepted only in a cycle with SirDack=1, delayed SirDack=0 and SirRead=0, using SirAddr/SirWdat of that cycle; exactly one write per SirSel assertion regardless of hold length.
REQ-006 SirRdat SHALL be register idx value in the cycle after a cycle with hit=1 and SirRead=1, else all zeros; reads SHALL have no side effects.
REQ-007 RW register: accepted write SHALL load SirWdat on the next edge.
REQ-008 RO register: value SHALL be HwIn slice registered every cycle; writes SHALL be acknowledged and ignored.
REQ-009 W1C register: each bit SHALL set when its HwIn bit is 1 and clear when an accepted write has 1 in that bit; simultaneous set and clear SHALL leave the bit set.
REQ-010 PULSE register: accepted write SHALL drive SirWdat onto Q for exactly one cycle, then Q SHALL return to 0; reads SHALL return 0 except during the pulse cycle.
REQ-011 WrStb[idx] SHALL be 1 for exactly the cycle in which register idx is updated by an accepted write, all modes including RO.
REQ-012 Out-of-range address SHALL give SirDack=0, SirRdat=0 and no register change.
REQ-013 SirSel held high while SirAddr changes SHALL NOT produce a second write; a new write requires SirSel (or hit) to drop for at least one cycle.
REQ-014 Latency: write visible on Q 2 cycles after first hit cycle; read data with SirDack 1 cycle after hit.

Reset
REQ-015 rst=1 SHALL immediately force SirDack=0, SirRdat=0, WrStb=0, delayed-ack flag=0, and each register to its INIT_VALUE slice (PULSE registers to 0, RO to INIT_VALUE until the first post-reset sample).
REQ-016 Reset asserted mid-transaction SHALL abort it with no write; if SirSel and hit remain high after release, SirDack SHALL rise next cycle and one write SHALL be accepted.

Verification
REQ-017 RW: write 0xDEADBEEF to BASEADDR+2 holding SirSel 4 cycles -> SirDack from cycle 2, Q reg2=0xDEADBEEF at cycle 3, WrStb[2] one pulse; read back -> SirRdat=0xDEADBEEF with SirDack.
REQ-018 W1C: HwIn reg3 bit0 and bit4 pulsed -> reg3=0x11; write 0x01 while HwIn bit0=1 -> reg3 stays 0x11; write 0x10 with HwIn=0 -> reg3=0x01.
REQ-019 PULSE/RO: write 0xA5 to PULSE reg -> Q=0xA5 exactly one cycle then 0; write 0x55 to RO reg with HwIn=0x33 -> SirDack=1, reg stays 0x33, WrStb pulses.
REQ-020 Boundaries: access BASEADDR-1 and BASEADDR+NUM_REGS -> SirDack=0, SirRdat=0, no Q change; access BASEADDR+NUM_REGS-1 -> normal ack; SirSel held 10 cycles with changing SirAddr -> single write only.
REQ-021 Reset: assert rst asynchronously in cycle 1 of a write to 0x1234 -> outputs cleared without a clock edge, register = INIT_VALUE; release with SirSel high -> one write of 0x1234 accepted.
